fft_stage_sequencer: RTL

Controller that schedules the butterfly unit for an in-place radix-2 decimation-in-time FFT of 2^N_LOG2 points. It walks stages and butterflies, generates read/write addresses for the dual-port sample memory, and drives the twiddle index for the twiddle lookup. It also aligns the write-back with the fixed memory and butterfly pipeline latency, and drains that pipeline between stages so no read-after-write hazard occurs. Input samples are already in bit-reversed order in memory; output is in natural order.

---
 rtl/fft_pkg.sv | 20 ++
 rtl/fft_addr_delay.sv | 41 ++++
 rtl/fft_stage_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants, state type and latency helper for the FFT stage sequencer.
package fft_pkg;

  localparam int N_LOG2_DEF   = 4;
  localparam int BFLY_LAT_DEF = 2;
  localparam int RD_LAT_DEF   = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Cycles from a read strobe to the matching write-back.
  function automatic int pipe_lat(input int rd_lat, input int bfly_lat);
    return rd_lat + bfly_lat;
  endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register carrying a valid bit plus payload; valid is
// clearable synchronously and by async reset, with an intermediate valid tap.
module fft_addr_delay
  import fft_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8,
  parameter int TAP   = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             tap_valid_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        vld_q[i] <= vld_q[i-1] & ~clr_i;
        dat_q[i] <= dat_q[i-1];
      end
      vld_q[0] <= valid_i & ~clr_i;
      dat_q[0] <= data_i;
    end
  end

  assign tap_valid_o = vld_q[TAP-1];
  assign valid_o     = vld_q[DEPTH-1];
  assign data_o      = dat_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT stage/butterfly scheduler with read/write address and twiddle
// generation. Optional issue gate: define FFT_SEQ_HOLD_EN to add hold_i.
//
// state    | meaning
// ST_IDLE  | waiting for start_i
// ST_RUN   | issuing one butterfly per cycle (k = 0..N/2-1)
// ST_DRAIN | waiting PIPE_LAT cycles for the stage's writes to land
// ST_DONE  | one-cycle completion pulse
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N_LOG2   = N_LOG2_DEF,
  parameter int BFLY_LAT = BFLY_LAT_DEF,
  parameter int RD_LAT   = RD_LAT_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
`ifdef FFT_SEQ_HOLD_EN
  input  logic                       hold_i,
`endif
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       rd_en_o,
  output logic [N_LOG2-1:0]          rd_addr_a_o,
  output logic [N_LOG2-1:0]          rd_addr_b_o,
  output logic [N_LOG2-2:0]          twiddle_index_o,
  output logic                       bfly_valid_o,
  output logic                       wr_en_o,
  output logic [N_LOG2-1:0]          wr_addr_a_o,
  output logic [N_LOG2-1:0]          wr_addr_b_o,
  output logic [$clog2(N_LOG2)-1:0]  stage_o
);

  localparam int PIPE_LAT = pipe_lat(RD_LAT, BFLY_LAT);
  localparam int KW       = N_LOG2 - 1;
  localparam int SW       = $clog2(N_LOG2);
  localparam int DW       = $clog2(PIPE_LAT + 1);

  localparam logic [KW-1:0] K_LAST     = '1;
  localparam logic [SW-1:0] STAGE_LAST = SW'(N_LOG2 - 1);
  localparam logic [SW-1:0] TW_TOP     = SW'(KW);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(PIPE_LAT - 1);

  seq_state_e    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          hold_w;
  logic          issue;
  logic          busy;
  logic          done;

`ifdef FFT_SEQ_HOLD_EN
  assign hold_w = hold_i;
`else
  assign hold_w = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      stage_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    drain_d = drain_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          k_d     = '0;
          stage_d = '0;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (!hold_w) begin
          issue = 1'b1;
          if (k_q == K_LAST) begin
            state_d = ST_DRAIN;
            k_d     = '0;
            drain_d = DRAIN_LOAD;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_q == '0) begin
          if (stage_q == STAGE_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            stage_d = stage_q + 1'b1;
          end
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
        stage_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address a inserts a zero at bit s of k; bit s of a is then always clear,
  // so OR-ing in the span is the same as adding it.
  logic [N_LOG2-1:0] kx, amask, addr_a, addr_b;
  logic [KW-1:0]     pos;
  logic [KW-1:0]     twiddle;
  logic [SW-1:0]     tw_sh;

  always_comb begin
    kx      = {1'b0, k_q};
    amask   = ~({N_LOG2{1'b1}} << stage_q);
    addr_a  = ((kx & ~amask) << 1) | (kx & amask);
    addr_b  = addr_a | (N_LOG2'(1) << stage_q);
    pos     = k_q & amask[KW-1:0];
    tw_sh   = TW_TOP - stage_q;
    twiddle = pos << tw_sh;
  end

  assign rd_en_o         = issue;
  assign rd_addr_a_o     = issue ? addr_a  : '0;
  assign rd_addr_b_o     = issue ? addr_b  : '0;
  assign twiddle_index_o = issue ? twiddle : '0;
  assign busy_o          = busy;
  assign done_o          = done;
  assign stage_o         = stage_q;

  fft_addr_delay #(
    .DEPTH (PIPE_LAT),
    .WIDTH (2 * N_LOG2),
    .TAP   (RD_LAT)
  ) u_delay (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (state_q == ST_IDLE),
    .valid_i     (issue),
    .data_i      ({rd_addr_a_o, rd_addr_b_o}),
    .tap_valid_o (bfly_valid_o),
    .valid_o     (wr_en_o),
    .data_o      ({wr_addr_a_o, wr_addr_b_o})
  );

endmodule
